// File: rtl/dcache_l2_write_buffer_if.sv
// Cache/memory-side bundle for the L2 write buffer. The buffer uses the slave view;
// the cache and memory model together use the master view.
interface dcache_l2_write_buffer_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DC_DW     = 256
);
  logic                 write_l2_valid_i;
  logic [ADDR_BITS-1:0] write_l2_addr_i;
  logic [DC_DW-1:0]     write_l2_data_i;
  logic                 wb_full_o;
  logic                 wb_empty_o;
  logic                 request_l2_valid_i;
  logic [ADDR_BITS-1:0] request_l2_addr_i;
  logic                 rd_ready_o;
  logic                 update_l2_valid_o;
  logic [ADDR_BITS-1:0] update_l2_addr_o;
  logic [DC_DW-1:0]     update_l2_data_o;
  logic                 mem_wr_valid_o;
  logic [ADDR_BITS-1:0] mem_wr_addr_o;
  logic [DC_DW-1:0]     mem_wr_data_o;
  logic                 mem_wr_ready_i;
  logic                 mem_rd_valid_o;
  logic [ADDR_BITS-1:0] mem_rd_addr_o;
  logic                 mem_rd_ready_i;
  logic                 mem_resp_valid_i;
  logic [ADDR_BITS-1:0] mem_resp_addr_i;
  logic [DC_DW-1:0]     mem_resp_data_i;

  modport slave (
    input  write_l2_valid_i, write_l2_addr_i, write_l2_data_i,
    input  request_l2_valid_i, request_l2_addr_i,
    input  mem_wr_ready_i, mem_rd_ready_i,
    input  mem_resp_valid_i, mem_resp_addr_i, mem_resp_data_i,
    output wb_full_o, wb_empty_o, rd_ready_o,
    output update_l2_valid_o, update_l2_addr_o, update_l2_data_o,
    output mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o,
    output mem_rd_valid_o, mem_rd_addr_o
  );

  modport master (
    output write_l2_valid_i, write_l2_addr_i, write_l2_data_i,
    output request_l2_valid_i, request_l2_addr_i,
    output mem_wr_ready_i, mem_rd_ready_i,
    output mem_resp_valid_i, mem_resp_addr_i, mem_resp_data_i,
    input  wb_full_o, wb_empty_o, rd_ready_o,
    input  update_l2_valid_o, update_l2_addr_o, update_l2_data_o,
    input  mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o,
    input  mem_rd_valid_o, mem_rd_addr_o
  );
endinterface

// File: rtl/dcache_l2_write_buffer.sv
// Coalescing write buffer between the D-cache L2 ports and memory, with read forwarding
// from buffered lines so reads never see stale memory behind a pending write.
module dcache_l2_write_buffer #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DC_DW     = 256,
  parameter int unsigned DEPTH     = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  dcache_l2_write_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StReq, StWait} rd_state_e;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [ADDR_BITS-1:0] addr_d [DEPTH];
  logic [DC_DW-1:0]     data_q [DEPTH];
  logic [DC_DW-1:0]     data_d [DEPTH];
  ptr_t                 head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  rd_state_e            state_q, state_d;
  logic                 hit_valid_q, hit_valid_d;
  logic [ADDR_BITS-1:0] hit_addr_q, hit_addr_d;
  logic [DC_DW-1:0]     hit_data_q, hit_data_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;

  logic                 full, empty, pop, push;
  logic                 wr_hit;
  ptr_t                 wr_idx;
  logic                 rd_ready;
  logic                 rd_hit;
  logic [DC_DW-1:0]     rd_hit_data;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.mem_wr_ready_i;

  // The head leaving this cycle is excluded so a rewrite of it lands in a fresh entry.
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.write_l2_addr_i) && !(pop && (ptr_t'(i) == head_q))) begin
        wr_hit = 1'b1;
        wr_idx = ptr_t'(i);
      end
    end
  end

  assign push = bus.write_l2_valid_i && !wr_hit && !full;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.write_l2_valid_i && wr_hit) begin
      data_d[wr_idx] = bus.write_l2_data_i;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.write_l2_addr_i;
      data_d[tail_q]  = bus.write_l2_data_i;
      tail_d          = tail_q + ptr_t'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_t'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Read lookup sees every valid entry (popping head included); incoming write wins.
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.request_l2_addr_i)) begin
        rd_hit      = 1'b1;
        rd_hit_data = data_q[i];
      end
    end
    if (bus.write_l2_valid_i && (bus.write_l2_addr_i == bus.request_l2_addr_i)) begin
      rd_hit      = 1'b1;
      rd_hit_data = bus.write_l2_data_i;
    end
  end

  assign rd_ready = (state_q == StIdle) && !hit_valid_q;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    hit_valid_d = hit_valid_q;
    hit_addr_d  = hit_addr_q;
    hit_data_d  = hit_data_q;
    // A pending hit yields to any memory response and retries the next cycle.
    if (hit_valid_q && !bus.mem_resp_valid_i) begin
      hit_valid_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (bus.request_l2_valid_i && rd_ready) begin
          if (rd_hit) begin
            hit_valid_d = 1'b1;
            hit_addr_d  = bus.request_l2_addr_i;
            hit_data_d  = rd_hit_data;
          end else begin
            rd_addr_d = bus.request_l2_addr_i;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        if (bus.mem_rd_ready_i) state_d = StWait;
      end
      StWait: begin
        if (bus.mem_resp_valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      hit_valid_q <= 1'b0;
      hit_addr_q  <= '0;
      hit_data_q  <= '0;
      rd_addr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hit_valid_q <= hit_valid_d;
      hit_addr_q  <= hit_addr_d;
      hit_data_q  <= hit_data_d;
      rd_addr_q   <= rd_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.wb_full_o         = full;
  assign bus.wb_empty_o        = empty;
  assign bus.mem_wr_valid_o    = !empty;
  assign bus.mem_wr_addr_o     = addr_q[head_q];
  assign bus.mem_wr_data_o     = data_q[head_q];
  assign bus.rd_ready_o        = rd_ready;
  assign bus.mem_rd_valid_o    = (state_q == StReq);
  assign bus.mem_rd_addr_o     = rd_addr_q;
  assign bus.update_l2_valid_o = bus.mem_resp_valid_i || hit_valid_q;
  assign bus.update_l2_addr_o  = bus.mem_resp_valid_i ? bus.mem_resp_addr_i : hit_addr_q;
  assign bus.update_l2_data_o  = bus.mem_resp_valid_i ? bus.mem_resp_data_i : hit_data_q;

endmodule
